// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest number of decimal digits that can hold 2**bin_w - 1.
  function automatic int min_digits(input int bin_w);
    longint unsigned max_v;
    longint unsigned pow10;
    int              d;
    max_v = (64'd1 << bin_w) - 64'd1;
    pow10 = 64'd10;
    d     = 1;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= max_v) begin
        d     = d + 1;
        pow10 = pow10 * 64'd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? 4'(i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble), one input bit per enabled cycle,
// with valid/ready handshakes on both sides and a global enable.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EN,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W must be in 1..32");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for 2**BIN_W - 1");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [BIN_W-1:0]   r_shift;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_corr;
  logic [ACC_W-1:0]   w_acc_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_bcd;
  logic               r_out_valid;
  logic               w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_corr[4*g +: 4])
    );
  end

  // The accumulator MSB shifted out here is always 0 given the DIGITS check.
  assign w_acc_next = (w_corr << 1) | {{(ACC_W-1){1'b0}}, r_shift[BIN_W-1]};
  assign w_last     = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) for all clocked state so every register sees pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = EN;
        if (EN && in_valid) w_state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (EN && w_last) w_state_next = DONE;
      end
      DONE: begin
        if (EN && out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_bcd       <= '0;
      r_out_valid <= 1'b0;
    end else if (EN) begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift <= bin;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          r_shift <= r_shift << 1;
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_bcd       <= w_acc_next;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: 8-bit/3-digit, 4-bit/2-digit and 1-bit/1-digit instances.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;

  logic        iv4, ir4, ov4, or4, busy4;
  logic [3:0]  bin4;
  logic [7:0]  bcd4;

  logic        iv1, ir1, ov1, or1, busy1;
  logic [0:0]  bin1;
  logic [3:0]  bcd1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .EN(en), .in_valid(iv8), .in_ready(ir8), .bin(bin8),
    .out_valid(ov8), .out_ready(or8), .bcd(bcd8), .busy(busy8));

  bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .EN(en), .in_valid(iv4), .in_ready(ir4), .bin(bin4),
    .out_valid(ov4), .out_ready(or4), .bcd(bcd4), .busy(busy4));

  bin2bcd_seq #(.BIN_W(1), .DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .EN(en), .in_valid(iv1), .in_ready(ir1), .bin(bin1),
    .out_valid(ov1), .out_ready(or1), .bcd(bcd1), .busy(busy1));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    while (!ov8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, p, busy_cnt, pulses, n_acc, n_res, cyc;
    logic        stable;
    logic [11:0] hold;
    logic [7:0]  exp4, got4;
    int          acc_cyc [2];
    logic [11:0] res [2];

    rst_n = 1'b0; en = 1'b1;
    iv8 = 1'b0; or8 = 1'b1; bin8 = '0;
    iv4 = 1'b0; or4 = 1'b1; bin4 = '0;
    iv1 = 1'b0; or1 = 1'b1; bin1 = '0;
    tick();
    check("rst_bcd",       32'(bcd8),  32'h0);
    check("rst_out_valid", 32'(ov8),   32'h0);
    check("rst_busy",      32'(busy8), 32'h0);
    check("rst_in_ready",  32'(ir8),   32'h1);
    rst_n = 1'b1;

    // 255: latency 8, busy exactly 8 cycles
    iv8 = 1'b1; bin8 = 8'd255;
    tick();
    iv8 = 1'b0; bin8 = 8'd0;
    lat = 0; busy_cnt = 0;
    while (!ov8 && lat < 40) begin
      if (busy8) busy_cnt++;
      tick();
      lat++;
    end
    check("255_latency", 32'(lat),      32'd8);
    check("255_busy",    32'(busy_cnt), 32'd8);
    check("255_bcd",     32'(bcd8),     32'h255);
    tick();
    check("255_consumed", 32'(ov8),  32'h0);
    check("255_ready",    32'(ir8),  32'h1);
    check("255_bcd_hold", 32'(bcd8), 32'h255);

    // 173 with EN paused for 5 cycles mid-SHIFT
    iv8 = 1'b1; bin8 = 8'd173;
    tick();
    iv8 = 1'b0;
    tick(); tick();
    en = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!busy8 || ov8 || ir8) stable = 1'b0;
    end
    check("173_paused", 32'(stable), 32'h1);
    en = 1'b1;
    p = 7;
    wait_valid8(lat);
    check("173_latency", 32'(p + lat), 32'd13);
    check("173_bcd",     32'(bcd8),    32'h173);
    tick();

    // 99 with 10 cycles of backpressure
    or8 = 1'b0;
    iv8 = 1'b1; bin8 = 8'd99;
    tick();
    iv8 = 1'b0; bin8 = 8'd7;
    wait_valid8(lat);
    check("99_latency", 32'(lat), 32'd8);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bcd8 !== 12'h099 || ov8 !== 1'b1 || ir8 !== 1'b0) stable = 1'b0;
    end
    check("99_backpressure", 32'(stable), 32'h1);
    or8 = 1'b1;
    tick();
    check("99_released_valid", 32'(ov8), 32'h0);
    check("99_released_ready", 32'(ir8), 32'h1);

    // reset during SHIFT cycle 3
    iv8 = 1'b1; bin8 = 8'd200;
    tick();
    iv8 = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_bcd",   32'(bcd8),  32'h0);
    check("midrst_valid", 32'(ov8),   32'h0);
    check("midrst_busy",  32'(busy8), 32'h0);
    check("midrst_ready", 32'(ir8),   32'h1);
    iv8 = 1'b1; bin8 = 8'd0;
    tick();
    iv8 = 1'b0;
    wait_valid8(lat);
    check("zero_latency", 32'(lat),  32'd8);
    check("zero_bcd",     32'(bcd8), 32'h000);
    tick();

    // back-to-back: 1 then 200 with in_valid held high
    iv8 = 1'b1; bin8 = 8'd1;
    n_acc = 0; n_res = 0; cyc = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; res[0] = '0; res[1] = '0;
    while (n_res < 2 && cyc < 60) begin
      hold = {11'd0, (ir8 && iv8)};
      tick();
      cyc++;
      if (hold[0]) begin
        if (n_acc < 2) acc_cyc[n_acc] = cyc;
        n_acc++;
        bin8 = 8'd200;
        if (n_acc == 2) iv8 = 1'b0;
      end
      if (ov8) begin
        if (n_res < 2) res[n_res] = bcd8;
        n_res++;
      end
    end
    check("b2b_results",   32'(n_res),                   32'd2);
    check("b2b_first",     32'(res[0]),                  32'h001);
    check("b2b_second",    32'(res[1]),                  32'h200);
    check("b2b_spacing",   32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
    iv8 = 1'b0;

    // 4-bit sweep against the legacy decimal table
    for (int b = 0; b < 16; b++) begin
      exp4 = (b < 10) ? 8'(b) : 8'(8'h10 + (b - 10));
      iv4 = 1'b1; bin4 = 4'(b);
      tick();
      iv4 = 1'b0; bin4 = 4'(15 - b);
      pulses = 0; got4 = 8'hee;
      for (int i = 0; i < 8; i++) begin
        if (ov4) begin
          pulses++;
          got4 = bcd4;
        end
        tick();
      end
      check($sformatf("sweep4_bcd_%0d", b),   32'(got4),   32'(exp4));
      check($sformatf("sweep4_pulse_%0d", b), 32'(pulses), 32'd1);
    end

    // BIN_W=1 finishes in one SHIFT cycle
    iv1 = 1'b1; bin1 = 1'b1;
    tick();
    iv1 = 1'b0; bin1 = 1'b0;
    check("w1_busy", 32'(busy1), 32'h1);
    tick();
    check("w1_valid", 32'(ov1),  32'h1);
    check("w1_bcd",   32'(bcd1), 32'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised, sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one input bit per cycle.
- Next generation of the 4-bit combinational encoder family: arbitrary input width and digit count, an enable, and valid/ready handshakes on both sides.
- Sits between a binary datapath (counters, ALU results) and BCD consumers such as 7-segment display drivers.

Parameters:
- BIN_W, 8, width of the binary input; legal range 1..32.
- DIGITS, 3, number of BCD output digits. Elaboration must fail if 10**DIGITS <= 2**BIN_W - 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- EN  input  1  global enable; low freezes all state except reset
- in_valid  input  1  bin is presented
- in_ready  output  1  converter can accept bin
- bin  input  BIN_W  unsigned binary operand
- out_valid  output  1  bcd holds a finished result
- out_ready  input  1  consumer accepts bcd
- bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0]
- busy  output  1  conversion in progress (state SHIFT)

Behaviour:
- Reset: one clk edge with rst_n=0 forces the following values, overriding EN and any in-flight conversion:
  - state=IDLE, bcd=0, out_valid=0, busy=0, shift register=0, counter=0.
  - in_ready follows its combinational definition, so it reads EN after reset.
- States:
  - IDLE: in_ready = EN. On an edge with EN && in_valid && in_ready:
    - Load shift register from bin.
    - Clear the BCD accumulator.
    - Set counter = BIN_W.
    - Go to SHIFT.
  - SHIFT: busy=1, in_ready=0. On each edge with EN=1:
    - Every accumulator digit >= 5 gets +3.
    - Then {accumulator, shift register} shifts left by 1.
    - Counter decrements.
    - When the counter reaches 0 on this edge, the shifted accumulator is registered into bcd, out_valid is set to 1, and the state goes to DONE.
  - DONE: out_valid=1, in_ready=0, and bcd is held stable.
    - On an edge with EN && out_ready: out_valid drops to 0 and the state goes to IDLE.
    - bcd keeps its last value after out_valid drops.
- Latency:
  - The accept edge is edge k.
  - With EN continuously high, out_valid is first high after edge k+BIN_W, i.e. BIN_W cycles of SHIFT.
  - The minimum cycle-to-cycle throughput is BIN_W+2 cycles per conversion.
- EN=0 in any state:
  - No state, counter, or data change occurs.
  - in_ready=0.
  - out_valid and bcd hold their values.
  - The handshake is ignored.
  - Resuming EN continues exactly where the block paused.
- Handshakes:
  - in_valid may rise at any time. bin is sampled only on the accept edge; later changes are ignored.
  - out_ready may be held high permanently; the result is then consumed on the first edge in DONE.
- Arithmetic:
  - The add-3 correction applies to all DIGITS digits every iteration, before the shift.
  - The accumulator is 4*DIGITS bits wide. The parameter check above guarantees no digit overflows.
  - The top bit shifted out of the accumulator is discarded; it is provably 0.
- Boundaries:
  - bin=0 gives bcd=0.
  - bin = 2**BIN_W - 1 gives the full decimal value.
  - BIN_W=1 completes in 1 SHIFT cycle.
  - The counter is $clog2(BIN_W+1) bits wide and never wraps.

Decomposition:
- Package bin2bcd_pkg:
  - state_t enum {IDLE, SHIFT, DONE}.
  - Constant function min_digits(bin_w), used for the elaboration check.
- Sub-module bcd_add3:
  - 4-bit combinational digit corrector: output = digit >= 5 ? digit + 3 : digit.
  - Instantiated DIGITS times via generate.

Test Plan:
- BIN_W=8, DIGITS=3, EN=1, out_ready=1, bin=8'd255 accepted at edge k -> out_valid rises after edge k+8, bcd=12'h255, busy high for exactly 8 cycles.
- BIN_W=4, DIGITS=2, sweep bin 0..15 -> bcd matches the legacy table, e.g. bin=4'd10 gives 8'h10 and bin=4'd15 gives 8'h15; out_valid asserted once per conversion.
- Drop EN to 0 for 5 cycles during SHIFT on bin=8'd173 -> busy stays high, no progress while paused, out_valid after 8+5 cycles, bcd=12'h173.
- Backpressure: out_ready=0 for 10 cycles in DONE with bin=8'd99 -> bcd=12'h099 stable, out_valid=1, in_ready=0; set out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-operation: rst_n=0 for one edge at SHIFT cycle 3 -> next cycle bcd=0, out_valid=0, busy=0, in_ready=1; then bin=8'd0 converts to 12'h000.
- Back-to-back: in_valid held high with bin=8'd1, then 8'd200, out_ready=1 -> results 12'h001 and 12'h200, accepts spaced exactly 10 cycles apart.
